// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types and defaults for the framed memory loader
package mem_loader_pkg;

    localparam int         ADDR_W          = 10;
    localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

    typedef enum logic [2:0] {
        IDLE,
        AH,
        AL,
        LH,
        LL,
        DATA,
        CHK
    } state_t;

endpackage

// File: rtl/mem_loader_timeout.sv
// rtl/mem_loader_timeout.sv - loadable down-counter with a one-cycle expiry strobe
module mem_loader_timeout #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    // Strobe on the decrement that takes the counter from 1 to 0.
    assign expired = dec && !load && (count == W'(1));

    // Reload wins over decrement; the counter parks at zero once expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed UART byte stream to memory writer with core passthrough
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter logic [15:0] TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int          AW        = ADDR_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    input  logic [AW-1:0] i_core_addr,
    input  logic          i_core_we,
    input  logic [7:0]    i_core_wdata,
    output logic          o_core_stall,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [7:0]    o_mem_wdata,
    output logic          o_done,
    output logic          o_err
);

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   remaining;
    logic [7:0]    sum;
    logic          expired;
    logic          passthrough;
    logic          data_write;

    // Any received byte rearms the inter-byte timer; silence only counts mid-frame.
    mem_loader_timeout #(
        .W (16)
    ) u_timeout (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (i_rx_valid),
        .load_value (TIMEOUT),
        .dec        ((state != IDLE) && !i_rx_valid),
        .expired    (expired)
    );

    assign passthrough = (state == IDLE) && !o_core_stall;
    assign data_write  = (state == DATA) && i_rx_valid;

    // Memory port mux: core owns it when idle, loader otherwise (writes only on data bytes).
    always_comb begin
        o_mem_addr  = cur_addr;
        o_mem_we    = data_write;
        o_mem_wdata = i_rx_data;
        if (passthrough) begin
            o_mem_addr  = i_core_addr;
            o_mem_we    = i_core_we;
            o_mem_wdata = i_core_wdata;
        end
    end

    // Frame parser FSM with registered stall/done/err; stall drops one cycle after returning to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_core_stall <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            cur_addr     <= '0;
            remaining    <= '0;
            sum          <= '0;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                o_core_stall <= 1'b0;
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state        <= AH;
                    o_core_stall <= 1'b1;
                    o_err        <= 1'b0;
                    sum          <= '0;
                end
            end else if (expired) begin
                state <= IDLE;
                o_err <= 1'b1;
            end else if (i_rx_valid) begin
                case (state)
                    AH: begin
                        cur_addr <= {(AW-8)'(i_rx_data[1:0]), 8'h00};
                        state    <= AL;
                    end
                    AL: begin
                        cur_addr <= {cur_addr[AW-1:8], i_rx_data};
                        state    <= LH;
                    end
                    LH: begin
                        remaining <= {1'b0, (AW-8)'(i_rx_data[1:0]), 8'h00};
                        state     <= LL;
                    end
                    LL: begin
                        // A zero length field means a full memory image.
                        if ({remaining[AW-1:8], i_rx_data} == '0) begin
                            remaining <= {1'b1, {AW{1'b0}}};
                        end else begin
                            remaining <= {1'b0, remaining[AW-1:8], i_rx_data};
                        end
                        state <= DATA;
                    end
                    DATA: begin
                        cur_addr  <= cur_addr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        sum       <= sum + i_rx_data;
                        if (remaining == (AW+1)'(1)) begin
                            state <= CHK;
                        end
                    end
                    CHK: begin
                        if (i_rx_data == sum) begin
                            o_done <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader against a frame-level model
module tb_mem_loader;

    localparam logic [15:0] TMO  = 16'd64;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [9:0] core_addr;
    logic       core_we;
    logic [7:0] core_wdata;
    logic       core_stall;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    bit in_frame = 1'b0;

    logic [7:0] cap_mem[1024];
    logic [7:0] ref_mem[1024];

    mem_loader #(
        .SYNC_BYTE (SYNC),
        .TIMEOUT   (TMO),
        .AW        (10)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .i_core_addr  (core_addr),
        .i_core_we    (core_we),
        .i_core_wdata (core_wdata),
        .o_core_stall (core_stall),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural memory fed by the DUT's memory port.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            cap_mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; returns at the falling edge for sampling.
    task automatic put(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        if (in_frame) begin
            core_we    = 1'($urandom);
            core_addr  = 10'($urandom);
            core_wdata = 8'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic frame_checks(input logic exp_we);
        check_eq("stall_in_frame", core_stall, 1);
        check_eq("err_in_frame", err, 0);
        check_eq("done_in_frame", done, 0);
        check_eq("we_in_frame", mem_we, exp_we);
    endtask

    task automatic gap(input int max_gap);
        int k;
        k = $urandom_range(0, max_gap);
        for (int g = 0; g < k; g++) begin
            put(1'b0, 8'($urandom));
            frame_checks(1'b0);
        end
    endtask

    // Sends a whole frame and checks the write stream and completion handshake.
    task automatic send_frame(input logic [9:0] base, input int n, input byte_q_t payload,
                              input bit good, input int max_gap);
        logic [7:0] s;
        logic [9:0] a;
        logic [9:0] lenf;
        logic [7:0] hdr[4];
        s    = 8'h00;
        a    = base;
        lenf = n[9:0];
        hdr[0] = {6'($urandom), base[9:8]};
        hdr[1] = base[7:0];
        hdr[2] = {6'($urandom), lenf[9:8]};
        hdr[3] = lenf[7:0];
        core_we = 1'b0;
        put(1'b1, SYNC);
        check_eq("sync_cycle_stall", core_stall, 0);
        in_frame = 1'b1;
        for (int h = 0; h < 4; h++) begin
            gap(max_gap);
            put(1'b1, hdr[h]);
            frame_checks(1'b0);
        end
        for (int i = 0; i < n; i++) begin
            gap(max_gap);
            put(1'b1, payload[i]);
            frame_checks(1'b1);
            check_eq("wr_addr", mem_addr, a);
            check_eq("wr_data", mem_wdata, payload[i]);
            ref_mem[a] = payload[i];
            s = s + payload[i];
            a = a + 10'd1;
        end
        gap(max_gap);
        put(1'b1, good ? s : s + 8'd1);
        frame_checks(1'b0);
        put(1'b0, 8'h00);
        check_eq("done_pulse", done, good);
        check_eq("err_result", err, !good);
        check_eq("stall_at_result", core_stall, 1);
        check_eq("we_at_result", mem_we, 0);
        in_frame = 1'b0;
        core_we  = 1'b0;
        put(1'b0, 8'h00);
        check_eq("done_one_cycle", done, 0);
        check_eq("stall_released", core_stall, 0);
        check_eq("err_sticky", err, !good);
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (cap_mem[i] !== ref_mem[i]) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        byte_q_t q;
        int      w0;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        core_addr = '0; core_we = 1'b0; core_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", core_stall, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_we", mem_we, 0);

        // Passthrough in IDLE
        @(posedge clk);
        #1 core_addr = 10'h155; core_we = 1'b1; core_wdata = 8'h3C;
        @(negedge clk);
        check_eq("pass_addr", mem_addr, 10'h155);
        check_eq("pass_we", mem_we, 1);
        check_eq("pass_wdata", mem_wdata, 8'h3C);
        check_eq("pass_stall", core_stall, 0);
        ref_mem[10'h155] = 8'h3C;
        @(posedge clk);
        #1 core_we = 1'b0;

        // Directed good frame
        q = '{8'h11, 8'h22, 8'h33};
        send_frame(10'h010, 3, q, 1'b1, 0);
        check_mem("mem_good_frame");

        // Wrap with length field zero (1024 bytes)
        q = {};
        for (int i = 0; i < 1024; i++) q.push_back(8'(i));
        send_frame(10'h3FF, 1024, q, 1'b1, 0);
        check_eq("wrap_3ff", cap_mem[10'h3FF], 8'h00);
        check_eq("wrap_000", cap_mem[10'h000], 8'h01);
        check_eq("wrap_3fe", cap_mem[10'h3FE], 8'hFF);

        // Bad checksum; err stays set while idle
        q = '{8'h11, 8'h22, 8'h33};
        send_frame(10'h010, 3, q, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            put(1'b0, 8'h00);
            check_eq("err_hold_idle", err, 1);
        end
        check_mem("mem_bad_frame");

        // Timeout after A5,00
        w0 = wr_count;
        put(1'b1, SYNC);
        in_frame = 1'b1;
        put(1'b1, 8'h00);
        frame_checks(1'b0);
        for (int k = 0; k < int'(TMO); k++) begin
            put(1'b0, 8'($urandom));
            frame_checks(1'b0);
        end
        put(1'b0, 8'h00);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_stall_hold", core_stall, 1);
        check_eq("tmo_no_done", done, 0);
        in_frame = 1'b0;
        core_we  = 1'b0;
        put(1'b0, 8'h00);
        check_eq("tmo_stall_rel", core_stall, 0);
        check_eq("tmo_no_writes", wr_count - w0, 0);
        @(posedge clk);
        #1 core_addr = 10'h2AA; core_we = 1'b1; core_wdata = 8'h5A;
        @(negedge clk);
        check_eq("tmo_pass_addr", mem_addr, 10'h2AA);
        check_eq("tmo_pass_we", mem_we, 1);
        check_eq("tmo_pass_wdata", mem_wdata, 8'h5A);
        check_eq("tmo_err_sticky", err, 1);
        ref_mem[10'h2AA] = 8'h5A;
        @(posedge clk);
        #1 core_we = 1'b0;

        // Reset mid-DATA after two of three bytes
        put(1'b1, SYNC);
        in_frame = 1'b1;
        put(1'b1, 8'h00);
        put(1'b1, 8'h20);
        put(1'b1, 8'h00);
        put(1'b1, 8'h03);
        put(1'b1, 8'hA5);
        check_eq("rstmid_we0", mem_we, 1);
        ref_mem[10'h020] = 8'hA5;
        put(1'b1, 8'h22);
        check_eq("rstmid_we1", mem_we, 1);
        ref_mem[10'h021] = 8'h22;
        in_frame = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1; rx_valid = 1'b0; core_we = 1'b0; core_addr = 10'h0F0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_stall", core_stall, 0);
        check_eq("rstmid_done", done, 0);
        check_eq("rstmid_err", err, 0);
        check_eq("rstmid_pass", mem_addr, 10'h0F0);
        q = '{8'h11, 8'h22, 8'h33};
        send_frame(10'h010, 3, q, 1'b1, 0);

        // Randomized frames with idle noise and inter-byte gaps
        for (int f = 0; f < 15; f++) begin
            int   n;
            logic [7:0] nb;
            n = $urandom_range(1, 48);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                nb = 8'($urandom);
                if (nb == SYNC) nb = 8'h5A;
                put(1'b1, nb);
                check_eq("noise_stall", core_stall, 0);
                check_eq("noise_we", mem_we, 0);
            end
            send_frame(10'($urandom), n, q, 1'($urandom), 3);
        end
        check_mem("mem_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
